// File: rtl/vector_ctrl_pkg.sv
// Shared types for the vector issue controller: control bundle, opcode classes,
// ALU source-3 selects and the beat-count helper.
package vector_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL = 2'b00,
    MEM  = 2'b01,
    DATA = 2'b10
  } instr_type_e;

  localparam logic [1:0] SRC3_PC  = 2'b00;
  localparam logic [1:0] SRC3_REG = 2'b01;
  localparam logic [1:0] SRC3_IMM = 2'b10;
  localparam logic [1:0] SRC3_BR  = 2'b11;

  typedef struct packed {
    logic       jump_i;
    logic       jump_ci;
    logic       jump_cd;
    logic       mem_to_reg;
    logic       mem_write;
    logic       imm_src;
    logic       vector_op;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_v_write;
    logic       reg_s_write;
    logic [1:0] alu_op;
    logic [1:0] alu_src3;
  } ctrl_t;

  function automatic int unsigned beats_f(input int unsigned vlen, input int unsigned lanes);
    return (lanes == 0) ? 0 : vlen / lanes;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: (type, func, imm, vector) -> control bundle plus legality.
module ctrl_decode
  import vector_ctrl_pkg::*;
(
  input  logic [1:0] instruction_type,
  input  logic [1:0] func,
  input  logic       imm,
  input  logic       vector,
  output ctrl_t      ctrl,
  output logic       legal
);

  always_comb begin
    ctrl  = '0;
    legal = 1'b0;
    case (instr_type_e'(instruction_type))
      CTRL: begin
        if (func == 2'b00 && !imm) begin
          legal         = 1'b1;
          ctrl.jump_ci  = 1'b1;
          ctrl.imm_src  = 1'b1;
          ctrl.alu_src3 = SRC3_BR;
        end else if (func == 2'b00 && imm) begin
          legal         = 1'b1;
          ctrl.jump_i   = 1'b1;
          ctrl.alu_src3 = SRC3_PC;
        end else if (func == 2'b01 && !imm) begin
          legal         = 1'b1;
          ctrl.jump_cd  = 1'b1;
          ctrl.imm_src  = 1'b1;
          ctrl.alu_src3 = SRC3_BR;
        end
      end
      MEM: begin
        if (func == 2'b00 || func == 2'b01) begin
          legal          = 1'b1;
          ctrl.imm_src   = 1'b1;
          ctrl.alu_src3  = SRC3_IMM;
          ctrl.alu_src1  = vector;
          ctrl.vector_op = vector;
          if (func == 2'b00) begin
            ctrl.mem_write = 1'b1;
          end else begin
            ctrl.mem_to_reg  = 1'b1;
            ctrl.reg_v_write = vector;
            ctrl.reg_s_write = !vector;
          end
        end
      end
      DATA: begin
        if (imm) begin
          // Immediate form is always scalar regardless of the vector flag.
          legal            = 1'b1;
          ctrl.imm_src     = 1'b1;
          ctrl.alu_src3    = SRC3_IMM;
          ctrl.reg_s_write = 1'b1;
          ctrl.alu_op      = func;
        end else if (func != 2'b11 && (func != 2'b10 || vector)) begin
          legal            = 1'b1;
          ctrl.alu_src3    = SRC3_REG;
          ctrl.alu_op      = func;
          ctrl.alu_src2    = vector;
          ctrl.vector_op   = vector;
          ctrl.reg_v_write = vector;
          ctrl.reg_s_write = !vector;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vector_issue_ctrl.sv
// Decode-and-issue controller: registers the decoded bundle and splits vector ops into
// VLEN/LANES beats. Optional illegal-instruction trap beat under ILLEGAL_TRAP_EN.
module vector_issue_ctrl
  import vector_ctrl_pkg::*;
#(
  parameter int unsigned VLEN  = 16,
  parameter int unsigned LANES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] instruction_type,
  input  logic [1:0] func,
  input  logic       imm,
  input  logic       vector,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       JumpI,
  output logic       JumpCI,
  output logic       JumpCD,
  output logic       MemToReg,
  output logic       MemWrite,
  output logic       ImmSrc,
  output logic       VectorOp,
  output logic       ALUSrc1,
  output logic       ALUSrc2,
  output logic       RegVWrite,
  output logic       RegSWrite,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrc3,
  output logic [((beats_f(VLEN, LANES) > 1) ? $clog2(beats_f(VLEN, LANES)) : 1)-1:0] beat_idx,
  output logic [((VLEN > 1) ? $clog2(VLEN) : 1)-1:0] elem_base,
  output logic       last_beat
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal,
  output logic       illegal_seen
`endif
);

  localparam int unsigned BEATS = beats_f(VLEN, LANES);
  localparam int unsigned BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned EBW   = (VLEN > 1) ? $clog2(VLEN) : 1;

  if (LANES == 0 || VLEN % LANES != 0) begin : g_bad_cfg
    $error("vector_issue_ctrl: VLEN must be a non-zero multiple of LANES");
  end

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [BIW-1:0]   beat_q, beat_d;
  logic [EBW-1:0]   elem_q, elem_d;
  ctrl_t            dec_ctrl;
  logic             dec_legal;
  logic             fire;
  logic             accept;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_q, illegal_d;
  logic             seen_q, seen_d;
`endif

  ctrl_decode u_dec (
    .instruction_type(instruction_type),
    .func            (func),
    .imm             (imm),
    .vector          (vector),
    .ctrl            (dec_ctrl),
    .legal           (dec_legal)
  );

  assign out_valid = (state_q == ISSUE);
  assign last_beat = out_valid && (!ctrl_q.vector_op || beat_q == BIW'(BEATS - 1));
  assign in_ready  = !out_valid || (out_ready && last_beat);
  assign fire      = out_valid && out_ready;
  assign accept    = in_valid && in_ready && !flush;

  // Next-state: flush squashes everything, otherwise drain beats and reload on accept.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    beat_d  = beat_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
    seen_d    = seen_q;
`endif
    if (flush) begin
      state_d = IDLE;
      ctrl_d  = '0;
      beat_d  = '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = 1'b0;
`endif
    end else begin
      if (fire) begin
        if (last_beat) begin
          state_d = IDLE;
          ctrl_d  = '0;
          beat_d  = '0;
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b0;
`endif
        end else begin
          beat_d = beat_q + BIW'(1);
        end
      end
      if (accept) begin
`ifdef ILLEGAL_TRAP_EN
        state_d   = ISSUE;
        ctrl_d    = dec_legal ? dec_ctrl : '0;
        beat_d    = '0;
        illegal_d = !dec_legal;
        seen_d    = seen_q | !dec_legal;
`else
        if (dec_legal) begin
          state_d = ISSUE;
          ctrl_d  = dec_ctrl;
          beat_d  = '0;
        end
`endif
      end
    end
    elem_d = EBW'(beat_d * LANES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      beat_q  <= '0;
      elem_q  <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
      seen_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      beat_q  <= beat_d;
      elem_q  <= elem_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
      seen_q    <= seen_d;
`endif
    end
  end

  assign JumpI     = ctrl_q.jump_i;
  assign JumpCI    = ctrl_q.jump_ci;
  assign JumpCD    = ctrl_q.jump_cd;
  assign MemToReg  = ctrl_q.mem_to_reg;
  assign MemWrite  = ctrl_q.mem_write;
  assign ImmSrc    = ctrl_q.imm_src;
  assign VectorOp  = ctrl_q.vector_op;
  assign ALUSrc1   = ctrl_q.alu_src1;
  assign ALUSrc2   = ctrl_q.alu_src2;
  assign RegVWrite = ctrl_q.reg_v_write;
  assign RegSWrite = ctrl_q.reg_s_write;
  assign ALUOp     = ctrl_q.alu_op;
  assign ALUSrc3   = ctrl_q.alu_src3;
  assign beat_idx  = beat_q;
  assign elem_base = elem_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal      = illegal_q;
  assign illegal_seen = seen_q;
`endif

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Self-checking bench for vector_issue_ctrl: directed literal cases plus randomized
// traffic checked against a beat-queue reference model every cycle.
module tb_vector_issue_ctrl;

  localparam int unsigned VLEN  = 16;
  localparam int unsigned LANES = 4;
  localparam int unsigned NBEAT = VLEN / LANES;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] instruction_type;
  logic [1:0] func;
  logic       imm;
  logic       vector;
  logic       out_valid;
  logic       out_ready;
  logic       JumpI, JumpCI, JumpCD, MemToReg, MemWrite, ImmSrc, VectorOp;
  logic       ALUSrc1, ALUSrc2, RegVWrite, RegSWrite;
  logic [1:0] ALUOp, ALUSrc3;
  logic [1:0] beat_idx;
  logic [3:0] elem_base;
  logic       last_beat;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
  logic       illegal_seen;
`endif

  vector_issue_ctrl #(.VLEN(VLEN), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction_type(instruction_type), .func(func), .imm(imm), .vector(vector),
    .out_valid(out_valid), .out_ready(out_ready),
    .JumpI(JumpI), .JumpCI(JumpCI), .JumpCD(JumpCD), .MemToReg(MemToReg),
    .MemWrite(MemWrite), .ImmSrc(ImmSrc), .VectorOp(VectorOp),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .RegVWrite(RegVWrite), .RegSWrite(RegSWrite),
    .ALUOp(ALUOp), .ALUSrc3(ALUSrc3),
    .beat_idx(beat_idx), .elem_base(elem_base), .last_beat(last_beat)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal), .illegal_seen(illegal_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Bundle order: JumpI JumpCI JumpCD MemToReg MemWrite ImmSrc VectorOp ALUSrc1 ALUSrc2 RegVWrite RegSWrite ALUOp ALUSrc3
  logic [14:0] act_ctrl;
  assign act_ctrl = {JumpI, JumpCI, JumpCD, MemToReg, MemWrite, ImmSrc, VectorOp,
                     ALUSrc1, ALUSrc2, RegVWrite, RegSWrite, ALUOp, ALUSrc3};

  // Reference decode straight from the opcode table.
  function automatic void ref_decode(input logic [1:0] t, input logic [1:0] f, input logic im,
                                     input logic v, output logic [14:0] c, output bit legal,
                                     output bit vop);
    bit ji, jci, jcd, m2r, mw, is, a1, a2, rv, rs;
    logic [1:0] op, s3;
    {ji, jci, jcd, m2r, mw, is, vop, a1, a2, rv, rs} = '0;
    op = 2'b00; s3 = 2'b00; legal = 0;
    if (t == 2'd0) begin
      if (f == 2'd0 && !im)      begin legal = 1; jci = 1; is = 1; s3 = 2'd3; end
      else if (f == 2'd0 && im)  begin legal = 1; ji = 1; s3 = 2'd0; end
      else if (f == 2'd1 && !im) begin legal = 1; jcd = 1; is = 1; s3 = 2'd3; end
    end else if (t == 2'd1) begin
      if (f == 2'd0 || f == 2'd1) begin
        legal = 1; is = 1; s3 = 2'd2; a1 = v; vop = v;
        if (f == 2'd0) mw = 1;
        else begin m2r = 1; rv = v; rs = !v; end
      end
    end else if (t == 2'd2) begin
      if (im) begin legal = 1; is = 1; s3 = 2'd2; rs = 1; op = f; end
      else if (f == 2'd0 || f == 2'd1 || (f == 2'd2 && v)) begin
        legal = 1; s3 = 2'd1; op = f; a2 = v; vop = v; rv = v; rs = !v;
      end
    end
    c = {ji, jci, jcd, m2r, mw, is, vop, a1, a2, rv, rs, op, s3};
  endfunction

  typedef struct {
    logic [14:0] c;
    int unsigned b;
    logic        ill;
  } beat_t;

  beat_t q[$];
  bit    zero_chk = 1;
  bit    seen_exp = 0;

  // Model: queue of beats still to be presented; the head is what the DUT must show.
  always @(negedge clk) begin
    int          n;
    logic        exp_rdy;
    logic [14:0] c;
    bit          lg;
    bit          vo;
    beat_t       e;
    int unsigned nb;
    n = q.size();
    exp_rdy = (n == 0) || (out_ready && n == 1);
    chk("m_out_valid", out_valid, 32'(n != 0));
    chk("m_in_ready", in_ready, 32'(exp_rdy));
    chk("m_last_beat", last_beat, 32'(n == 1));
    if (n != 0) begin
      chk("m_beat_idx", beat_idx, q[0].b);
      chk("m_elem_base", elem_base, q[0].b * LANES);
      chk("m_ctrl", act_ctrl, q[0].c);
`ifdef ILLEGAL_TRAP_EN
      chk("m_illegal", illegal, q[0].ill);
`endif
    end else if (zero_chk) begin
      chk("m_idle_beat", beat_idx, 0);
      chk("m_idle_elem", elem_base, 0);
      chk("m_idle_ctrl", act_ctrl, 0);
    end
`ifdef ILLEGAL_TRAP_EN
    chk("m_illegal_seen", illegal_seen, 32'(seen_exp));
`endif
    if (rst) begin
      q.delete();
      zero_chk = 1;
      seen_exp = 0;
    end else if (flush) begin
      q.delete();
      zero_chk = 1;
    end else begin
      if (n != 0 && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        ref_decode(instruction_type, func, imm, vector, c, lg, vo);
        if (lg) begin
          nb = vo ? NBEAT : 1;
          for (int unsigned i = 0; i < nb; i++) begin
            e.c = c; e.b = i; e.ill = 1'b0;
            q.push_back(e);
          end
          zero_chk = 0;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          e.c = '0; e.b = 0; e.ill = 1'b1;
          q.push_back(e);
          seen_exp = 1;
          zero_chk = 0;
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [1:0] t, input logic [1:0] f,
                     input logic im, input logic vec);
    in_valid = v; instruction_type = t; func = f; imm = im; vector = vec;
  endtask

  int ld_rdy [6] = '{1, 0, 0, 1, 1, 1};
  int ld_beat[6] = '{0, 1, 1, 1, 2, 3};

  initial begin
    int xfers;
    rst = 1; flush = 0; out_ready = 1;
    put(0, 2'd0, 2'd0, 0, 0);
    tick(); tick();
    rst = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_last", last_beat, 0);
    chk("rst_ctrl", act_ctrl, 0);

    // Scalar add
    put(1, 2'd2, 2'd0, 0, 0);
    tick(); put(0, 2'd0, 2'd0, 0, 0); #2;
    chk("add_valid", out_valid, 1);
    chk("add_regswrite", RegSWrite, 1);
    chk("add_src3", ALUSrc3, 2'b01);
    chk("add_aluop", ALUOp, 2'b00);
    chk("add_last", last_beat, 1);
    chk("add_beat", beat_idx, 0);
    tick();

    // Vector op2, four beats
    put(1, 2'd2, 2'd2, 0, 1);
    tick(); put(0, 2'd0, 2'd0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      #2;
      chk("vop_beat", beat_idx, b);
      chk("vop_elem", elem_base, 4 * b);
      chk("vop_last", last_beat, 32'(b == 3));
      chk("vop_in_ready", in_ready, 32'(b == 3));
      chk("vop_regv_src2", {RegVWrite, ALUSrc2}, 2'b11);
      tick();
    end

    // Vector load with stalls
    put(1, 2'd1, 2'd1, 0, 1);
    tick(); put(0, 2'd0, 2'd0, 0, 0);
    xfers = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready = ld_rdy[i][0];
      #2;
      chk("ld_beat", beat_idx, ld_beat[i]);
      chk("ld_memtoreg_regv", {MemToReg, RegVWrite, out_valid}, 3'b111);
      if (out_valid && out_ready) xfers++;
      tick();
    end
    out_ready = 1; #2;
    chk("ld_xfers", xfers, 4);
    chk("ld_done", out_valid, 0);
    tick();

    // Flush during beat 2 of a vector store
    put(1, 2'd1, 2'd0, 0, 1);
    tick(); put(0, 2'd0, 2'd0, 0, 0);
    tick(); tick(); #2;
    chk("st_beat2", beat_idx, 2);
    flush = 1;
    put(1, 2'd0, 2'd0, 1, 0);
    tick(); flush = 0; put(0, 2'd0, 2'd0, 0, 0); #2;
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_beat", beat_idx, 0);
    chk("fl_ctrl", act_ctrl, 0);
    put(1, 2'd0, 2'd0, 1, 0);
    tick(); put(0, 2'd0, 2'd0, 0, 0); #2;
    chk("jmp_valid_last", {out_valid, last_beat}, 2'b11);
    chk("jmp_jumpi", JumpI, 1);
    chk("jmp_src3", ALUSrc3, 2'b00);
    tick();

    // Back-to-back scalar sub then scalar load
    put(1, 2'd2, 2'd1, 0, 0);
    tick();
    put(1, 2'd1, 2'd1, 0, 0); #2;
    chk("sub_aluop", ALUOp, 2'b01);
    chk("sub_in_ready", in_ready, 1);
    tick(); put(0, 2'd0, 2'd0, 0, 0); #2;
    chk("bb_valid", out_valid, 1);
    chk("bb_load", {MemToReg, RegSWrite}, 2'b11);
    tick();

    // Illegal opcode
    put(1, 2'd3, 2'd0, 0, 0);
    tick(); put(0, 2'd0, 2'd0, 0, 0); #2;
`ifdef ILLEGAL_TRAP_EN
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_ctrl", act_ctrl, 0);
    tick(); tick(); #2;
    chk("ill_seen_sticky", illegal_seen, 1);
`else
    chk("ill_no_beat", out_valid, 0);
    chk("ill_in_ready", in_ready, 1);
`endif
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      put(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    rst = 1; flush = 0; put(0, 2'd0, 2'd0, 0, 0);
    tick(); rst = 0; #2;
    chk("end_rst_valid", out_valid, 0);
    chk("end_rst_in_ready", in_ready, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
